// File: rtl/serial_adder_ctrl.sv
// Serial add/subtract sequencer: one 2-bit adder slice handles one base-4 digit per cycle,
// from LSB to MSB. The start/busy/done handshake lets a narrow slice replace a wide adder.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is sampled only in IDLE; busy marks RUN; done is a one-cycle
    // pulse marking sum/cout as freshly updated. busy and done are never high together.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       slice_d;
    logic [WIDTH-1:0] acc_d;
    logic             last_d;

    always_comb begin
        slice_d = {1'b0, op_a_q[1:0]} + {1'b0, op_b_q[1:0]} + {2'b00, carry_q};
        // Accumulator is cleared at start, so OR-ing the new digit into place is enough.
        acc_d   = acc_q | (WIDTH'(slice_d[1:0]) << {idx_q, 1'b0});
        last_d  = (idx_q == IW'(DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_d[2];
                    op_a_q  <= op_a_q >> 2;
                    op_b_q  <= op_b_q >> 2;
                    idx_q   <= idx_q + IW'(1);
                    if (last_d) begin
                        sum_q   <= acc_d;
                        cout_q  <= slice_d[2];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign dbg_state = state_q;
endmodule
